// File: rtl/fulladder4.sv
// Single-bit full adder with a registered, valid-qualified output stage and an
// optional bit-serial carry chain for LSB-first multi-bit addition.
module fulladder4 #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned OUT_REG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             x,
    input  logic             y,
    input  logic             cin,
    input  logic             chain_en,
    input  logic             chain_clr,
    output logic             sum_comb,
    output logic             carry_comb,
    output logic             sum,
    output logic             carry,
    output logic             out_valid,
    output logic             carry_state,
    output logic [CNT_W-1:0] vec_cnt
);

    logic             ci;
    logic             carry_state_q;
    logic             carry_state_d;
    logic [CNT_W-1:0] vec_cnt_q;
    logic [CNT_W-1:0] vec_cnt_d;

    // chain_clr wins over both carry sources so a new word always starts from 0
    assign ci = chain_clr ? 1'b0 : (chain_en ? carry_state_q : cin);

    // Full-adder core on the effective carry-in; independent of clock and reset
    always_comb begin
        sum_comb   = x ^ y ^ ci;
        carry_comb = (x & y) | (x & ci) | (y & ci);
    end

    // Chain carry: an accepted chained bit captures its carry-out, else a clear zeroes it
    always_comb begin
        carry_state_d = carry_state_q;
        if (in_valid && chain_en) begin
            carry_state_d = carry_comb;
        end else if (chain_clr) begin
            carry_state_d = 1'b0;
        end
    end

    // Operand counter, wraps naturally at 2^CNT_W
    always_comb begin
        vec_cnt_d = vec_cnt_q;
        if (in_valid) begin
            vec_cnt_d = vec_cnt_q + CNT_W'(1);
        end
    end

    // Chain carry and operand count state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_state_q <= 1'b0;
            vec_cnt_q     <= '0;
        end else begin
            carry_state_q <= carry_state_d;
            vec_cnt_q     <= vec_cnt_d;
        end
    end

    assign carry_state = carry_state_q;
    assign vec_cnt     = vec_cnt_q;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic sum_q;
            logic carry_q;
            logic out_valid_q;

            // Result register: load on accepted operand, hold otherwise
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q       <= 1'b0;
                    carry_q     <= 1'b0;
                    out_valid_q <= 1'b0;
                end else begin
                    out_valid_q <= in_valid;
                    if (in_valid) begin
                        sum_q   <= sum_comb;
                        carry_q <= carry_comb;
                    end
                end
            end

            assign sum       = sum_q;
            assign carry     = carry_q;
            assign out_valid = out_valid_q;
        end else begin : g_out_comb
            assign sum       = sum_comb;
            assign carry     = carry_comb;
            assign out_valid = in_valid;
        end
    endgenerate

endmodule

// File: tb/tb_fulladder4.sv
// Scoreboard bench for fulladder4: registered instance (CNT_W=8, OUT_REG=1) checked
// through a queue/monitor, plus a CNT_W=2, OUT_REG=0 instance on the same inputs.
module tb_fulladder4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic x = 1'b0;
    logic y = 1'b0;
    logic cin = 1'b0;
    logic chain_en = 1'b0;
    logic chain_clr = 1'b0;

    logic       sum_comb, carry_comb, sum, carry, out_valid, carry_state;
    logic [7:0] vec_cnt;
    logic       sum_comb2, carry_comb2, sum2, carry2, out_valid2, carry_state2;
    logic [1:0] vec_cnt2;

    int checks = 0;
    int failures = 0;
    int pushes = 0;
    int pops = 0;
    logic [1:0] sb_q[$];

    always #5 clk = ~clk;

    fulladder4 #(.CNT_W(8), .OUT_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y), .cin(cin),
        .chain_en(chain_en), .chain_clr(chain_clr), .sum_comb(sum_comb),
        .carry_comb(carry_comb), .sum(sum), .carry(carry), .out_valid(out_valid),
        .carry_state(carry_state), .vec_cnt(vec_cnt)
    );

    fulladder4 #(.CNT_W(2), .OUT_REG(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y), .cin(cin),
        .chain_en(chain_en), .chain_clr(chain_clr), .sum_comb(sum_comb2),
        .carry_comb(carry_comb2), .sum(sum2), .carry(carry2), .out_valid(out_valid2),
        .carry_state(carry_state2), .vec_cnt(vec_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; es/ec are hand-computed sum/carry
    task automatic apply(input logic v, input logic xx, input logic yy, input logic cc,
                         input logic ce, input logic cl, input logic es, input logic ec);
        @(negedge clk);
        in_valid  = v;
        x         = xx;
        y         = yy;
        cin       = cc;
        chain_en  = ce;
        chain_clr = cl;
        if (v) begin
            sb_q.push_back({es, ec});
            pushes++;
        end
        #1;
        chk("sum_comb", sum_comb, es);
        chk("carry_comb", carry_comb, ec);
        chk("nr_sum", sum2, es);
        chk("nr_carry", carry2, ec);
        chk("nr_out_valid", out_valid2, v);
    endtask

    // Monitor: every registered result presented must match the oldest expectation
    initial begin
        logic [1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && out_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual=out_valid required=no_output");
                end else begin
                    e = sb_q.pop_front();
                    pops++;
                    chk("sb_sum", sum, e[1]);
                    chk("sb_carry", carry, e[0]);
                end
            end
        end
    end

    logic [4:0] tt [8];

    initial begin
        // {x,y,cin,sum,carry}
        tt[0] = 5'b000_00; tt[1] = 5'b010_10; tt[2] = 5'b100_10; tt[3] = 5'b110_01;
        tt[4] = 5'b001_10; tt[5] = 5'b011_01; tt[6] = 5'b101_01; tt[7] = 5'b111_11;

        // Reset state, and comb path alive during reset
        #2;
        chk("rst_sum", sum, 0);
        chk("rst_carry", carry, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_carry_state", carry_state, 0);
        chk("rst_vec_cnt", vec_cnt, 0);
        x = 1'b1;
        #1;
        chk("rst_comb_sum", sum_comb, 1);
        x = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Truth table
        for (int i = 0; i < 8; i++) begin
            apply(1, tt[i][4], tt[i][3], tt[i][2], 0, 0, tt[i][1], tt[i][0]);
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        chk("tt_vec_cnt", vec_cnt, 8);
        chk("tt_vec_cnt2", vec_cnt2, 0);
        chk("tt_carry_state", carry_state, 0);

        // Single pulse latency and hold
        apply(1, 1, 1, 0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lat_out_valid_hi", out_valid, 1);
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lat_out_valid_lo", out_valid, 0);
        chk("lat_sum_hold", sum, 0);
        chk("lat_carry_hold", carry, 1);

        // Bit-serial 0111 + 0001
        apply(1, 1, 1, 0, 1, 1, 0, 1);
        apply(1, 1, 0, 0, 1, 0, 0, 1);
        chk("bs_cs0", carry_state, 1);
        apply(1, 1, 0, 0, 1, 0, 0, 1);
        chk("bs_cs1", carry_state, 1);
        apply(1, 0, 0, 0, 1, 0, 1, 0);
        chk("bs_cs2", carry_state, 1);
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        chk("bs_cs3", carry_state, 0);

        // Clear priority: carry_state=1 then clear-and-add
        apply(1, 1, 1, 0, 1, 1, 0, 1);
        apply(1, 1, 0, 0, 1, 1, 1, 0);
        chk("clr_pre_cs", carry_state, 1);
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        chk("clr_cs", carry_state, 0);

        // Unchained operand holds carry_state; idle clear zeroes it
        apply(1, 1, 1, 1, 1, 1, 0, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        chk("hold_pre_cs", carry_state, 1);
        apply(0, 0, 0, 0, 0, 1, 0, 0);
        chk("hold_cs", carry_state, 1);
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        chk("idle_clr_cs", carry_state, 0);

        // Async reset mid-stream
        apply(1, 1, 1, 0, 1, 1, 0, 1);
        apply(1, 1, 1, 1, 0, 0, 1, 1);
        chk("ar_pre_cs", carry_state, 1);
        chk("ar_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("ar_sum", sum, 0);
        chk("ar_carry", carry, 0);
        chk("ar_out_valid", out_valid, 0);
        chk("ar_cs", carry_state, 0);
        chk("ar_vec_cnt", vec_cnt, 0);
        chk("ar_vec_cnt2", vec_cnt2, 0);
        sb_q.delete();
        pushes--;
        @(negedge clk);
        rst_n = 1'b1;
        apply(1, 1, 0, 0, 1, 0, 1, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        chk("ar_post_vec_cnt", vec_cnt, 1);
        chk("ar_post_cs", carry_state, 0);

        // Counter wrap on the 2-bit instance
        for (int i = 0; i < 4; i++) begin
            apply(1, 1, 0, 1, 0, 0, 0, 1);
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap_vec_cnt", vec_cnt, 5);
        chk("wrap_vec_cnt2", vec_cnt2, 1);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        chk("sb_pop_count", pops, pushes);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fulladder4.md
Name: fulladder4

Overview:
- Single-bit full adder (x + y + cin -> sum, carry) with a registered, valid-qualified output stage.
- Optional bit-serial carry-chain mode: the stored carry feeds the next bit, so multi-bit words can be added LSB-first.
- Used as a basic arithmetic leaf cell and as a bit-serial adder in control-path datapaths.
- Pure combinational outputs are also exported for zero-latency use.

Parameters:
- CNT_W, 8, width of the processed-vector counter (vec_cnt).
- OUT_REG, 1, 1 = sum/carry/out_valid registered (1-cycle latency); 0 = they equal the combinational values and in_valid, with no latency.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand strobe; x/y/cin are sampled when high.
- x  input  1  addend bit.
- y  input  1  addend bit.
- cin  input  1  external carry-in (ignored when chain_en=1).
- chain_en  input  1  1 = use the internal carry_state as carry-in (bit-serial mode).
- chain_clr  input  1  forces the effective carry-in to 0 this cycle and clears carry_state.
- sum_comb  output  1  combinational sum of the current inputs.
- carry_comb  output  1  combinational carry of the current inputs.
- sum  output  1  registered sum (per OUT_REG).
- carry  output  1  registered carry-out (per OUT_REG).
- out_valid  output  1  sum/carry valid strobe.
- carry_state  output  1  stored chain carry.
- vec_cnt  output  CNT_W  count of accepted operands.

Behaviour:
- Effective carry-in: ci = chain_clr ? 0 : (chain_en ? carry_state : cin).
- sum_comb = x ^ y ^ ci.
- carry_comb = (x & y) | (x & ci) | (y & ci).
- Combinational outputs are valid regardless of in_valid and follow the inputs with no clock involvement.
- Reset (rst_n=0, asynchronous, immediate): sum=0, carry=0, out_valid=0, carry_state=0, vec_cnt=0. Combinational outputs are unaffected by reset.
- OUT_REG=1, rising clk with in_valid=1: sum<=sum_comb, carry<=carry_comb, out_valid<=1.
- OUT_REG=1, rising clk with in_valid=0: out_valid<=0; sum/carry hold their previous values.
- OUT_REG=0: sum=sum_comb, carry=carry_comb, out_valid=in_valid.
- carry_state update, rising clk, evaluated in priority order:
  - in_valid=1 and chain_en=1: carry_state<=carry_comb. Since ci=0 when chain_clr=1, this is "clear then add" and starts a new word.
  - else chain_clr=1: carry_state<=0.
  - else hold.
- chain_en=0 with in_valid=1 and chain_clr=0: carry_state holds (not overwritten).
- vec_cnt increments by 1 on every rising clk with in_valid=1; wraps from 2^CNT_W-1 to 0; chain_clr does not affect it.
- Reset asserted mid-operation discards any in-flight result. The first valid after rst_n deasserts uses carry_state=0.
- No backpressure; one operand accepted per cycle, throughput 1/cycle.

Test Plan:
- Truth table, chain_en=0, chain_clr=0: apply (x,y,cin) = 000,010,100,110,001,011,101,111, in_valid=1, one vector per cycle -> (sum,carry) = 00,10,10,01,10,01,01,11 on sum_comb/carry_comb immediately and on sum/carry one cycle later (OUT_REG=1); vec_cnt=8 afterwards.
- Latency/valid: single in_valid pulse with x=1,y=1,cin=0 -> out_valid high for exactly the following cycle, sum=0, carry=1; sum/carry hold after out_valid drops.
- Bit-serial add: chain_en=1; first bit with chain_clr=1; feed 0111+0001 LSB-first -> sum bits 0,0,0,1 (result 1000), carry_state 1,1,1,0 after each bit.
- Clear priority: carry_state=1, then chain_en=1, chain_clr=1, x=1, y=0 -> sum=1, carry=0, carry_state=0.
- Async reset: assert rst_n=0 between clock edges during a valid stream -> sum, carry, out_valid, carry_state, vec_cnt go to 0 immediately without a clock edge; normal operation resumes on the first edge after release.
- Counter wrap (CNT_W=2): 5 valid operands -> vec_cnt=1; OUT_REG=0 build -> out_valid tracks in_valid with zero latency.
